dmem_responder: RTL and testbench

- Memory-side responder to the Processor core's instruction-fetch and data ports.
- The fetch port answers `pc` with `inst`. The data port answers `mem_addr`/`mem_out`/`we` with `mem_in`.
- Backing storage models a slow write path. Processor stores are absorbed by a small store buffer, then drained into the array by a write FSM.
- Loads see buffered stores through store-to-load forwarding.

---
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Memory-side responder: registered fetch and load ports over a word array.
// Stores pass through a store buffer and a drain FSM; DMEM_FWD_EN enables store-to-load forwarding.
module dmem_responder #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 10,
   parameter int SB_DEPTH  = 4,
   parameter int WR_CYCLES = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_W-1:0]           pc,
   output logic [DATA_W-1:0]           inst,
   input  logic [DATA_W-1:0]           mem_addr,
   input  logic [DATA_W-1:0]           mem_out,
   input  logic                        we,
   output logic [DATA_W-1:0]           mem_in,
   output logic [$clog2(SB_DEPTH):0]   sb_count,
   output logic                        sb_full,
   output logic                        overflow
);

   localparam int PTR_W = $clog2(SB_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WC_W  = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
   localparam logic [WC_W-1:0]  WC_LOAD = WC_W'(WR_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEPTH   = CNT_W'(SB_DEPTH);

   typedef enum logic {IDLE, BUSY} state_t;

   logic [DATA_W-1:0] mem     [2**ADDR_W];
   logic [ADDR_W-1:0] sb_addr [SB_DEPTH];
   logic [DATA_W-1:0] sb_data [SB_DEPTH];

   logic [PTR_W-1:0]  head, tail;
   logic [WC_W-1:0]   wcnt;
   state_t            state;

   logic [ADDR_W-1:0] fetch_a, ld_a, st_a;
   logic              pop, push;
   logic [DATA_W-1:0] ld_data;
   logic              unused_hi;

   assign fetch_a   = pc[ADDR_W-1:0];
   assign ld_a      = mem_addr[ADDR_W-1:0];
   assign st_a      = mem_addr[ADDR_W-1:0];
   assign unused_hi = ^{pc[DATA_W-1:ADDR_W], mem_addr[DATA_W-1:ADDR_W]};

   assign sb_full = (sb_count == DEPTH);
   assign pop     = (state == BUSY) && (wcnt == '0);
   // A full buffer still accepts a store on the edge its head drains.
   assign push    = we && (!sb_full || pop);

`ifdef DMEM_FWD_EN
   logic [PTR_W-1:0] idx;
   // Scan oldest to youngest so the youngest matching entry wins.
   always_comb begin
      ld_data = mem[ld_a];
      idx     = '0;
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if ((CNT_W'(i) < sb_count) && (sb_addr[idx] == ld_a))
            ld_data = sb_data[idx];
      end
      if (push && (st_a == ld_a))
         ld_data = mem_out;
   end
`else
   always_comb begin
      ld_data = mem[ld_a];
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst && pop)
         mem[sb_addr[head]] <= sb_data[head];
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         sb_addr[tail] <= st_a;
         sb_data[tail] <= mem_out;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inst     <= '0;
         mem_in   <= '0;
         sb_count <= '0;
         head     <= '0;
         tail     <= '0;
         wcnt     <= '0;
         state    <= IDLE;
         overflow <= 1'b0;
      end else begin
         inst   <= mem[fetch_a];
         mem_in <= ld_data;

         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;

         case ({push, pop})
            2'b10:   sb_count <= sb_count + 1'b1;
            2'b01:   sb_count <= sb_count - 1'b1;
            default: sb_count <= sb_count;
         endcase

         if (we && !push)
            overflow <= 1'b1;

         case (state)
            IDLE: begin
               if (sb_count != '0) begin
                  state <= BUSY;
                  wcnt  <= WC_LOAD;
               end
            end
            BUSY: begin
               if (wcnt != '0)
                  wcnt <= wcnt - 1'b1;
               else if ((sb_count > CNT_W'(1)) || push)
                  wcnt <= WC_LOAD;
               else
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder; expectations adapt to the DMEM_FWD_EN build option.
module tb_dmem_responder;

   localparam int DATA_W = 32;

`ifdef DMEM_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DATA_W-1:0] pc = '0, mem_addr = '0, mem_out = '0;
   logic              we = 1'b0;
   logic [DATA_W-1:0] inst, mem_in;
   logic [2:0]        sb_count;
   logic              sb_full, overflow;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   dmem_responder #(.DATA_W(32), .ADDR_W(10), .SB_DEPTH(4), .WR_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .pc(pc), .inst(inst), .mem_addr(mem_addr),
      .mem_out(mem_out), .we(we), .mem_in(mem_in), .sb_count(sb_count),
      .sb_full(sb_full), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] e_inst;
      logic [31:0] e_mem;
      logic [31:0] e_cnt;
      bit          e_full;
      bit          e_ovf;
   } vec_t;

   vec_t vecs[32];

   function automatic vec_t v(bit w, logic [31:0] p, logic [31:0] a, logic [31:0] d,
                              logic [31:0] ei, logic [31:0] em, logic [31:0] ec,
                              bit ef, bit eo);
      vec_t r;
      r.we = w; r.pc = p; r.addr = a; r.data = d;
      r.e_inst = ei; r.e_mem = em; r.e_cnt = ec; r.e_full = ef; r.e_ovf = eo;
      return r;
   endfunction

   function automatic logic [31:0] f(logic [31:0] with_fwd, logic [31:0] without_fwd);
      return FWD ? with_fwd : without_fwd;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit w, input logic [31:0] p, input logic [31:0] a, input logic [31:0] d);
      we = w; pc = p; mem_addr = a; mem_out = d;
   endtask

   initial begin
      // Rows are consecutive cycles; expected values are sampled just after each edge.
      for (int i = 0; i < 3; i++) vecs[i] = v(0, 0, 0, 0, 32'h1000, 32'h1000, 0, 0, 0);
      vecs[3]  = v(1, 5, 5, 32'hDEADBEEF, 32'h1005, f(32'hDEADBEEF, 32'h1005), 1, 0, 0);
      vecs[4]  = v(0, 5, 5, 0, 32'h1005, f(32'hDEADBEEF, 32'h1005), 1, 0, 0);
      vecs[5]  = v(0, 5, 5, 0, 32'h1005, f(32'hDEADBEEF, 32'h1005), 1, 0, 0);
      vecs[6]  = v(0, 5, 5, 0, 32'h1005, f(32'hDEADBEEF, 32'h1005), 0, 0, 0);
      vecs[7]  = v(0, 5, 5, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
      vecs[8]  = v(1, 7, 7, 32'h11, 32'h1007, f(32'h11, 32'h1007), 1, 0, 0);
      vecs[9]  = v(1, 7, 7, 32'h22, 32'h1007, f(32'h22, 32'h1007), 2, 0, 0);
      vecs[10] = v(0, 7, 7, 0, 32'h1007, f(32'h22, 32'h1007), 2, 0, 0);
      vecs[11] = v(1, 7, 7, 32'h33, 32'h1007, f(32'h33, 32'h1007), 2, 0, 0);
      vecs[12] = v(0, 7, 7, 0, 32'h11, f(32'h33, 32'h11), 2, 0, 0);
      vecs[13] = v(0, 7, 7, 0, 32'h11, f(32'h33, 32'h11), 1, 0, 0);
      vecs[14] = v(0, 7, 7, 0, 32'h22, f(32'h33, 32'h22), 1, 0, 0);
      vecs[15] = v(0, 7, 7, 0, 32'h22, f(32'h33, 32'h22), 0, 0, 0);
      vecs[16] = v(0, 7, 7, 0, 32'h33, 32'h33, 0, 0, 0);
      vecs[17] = v(1, 0, 8,  32'hA0, 32'h1000, f(32'hA0, 32'h1008), 1, 0, 0);
      vecs[18] = v(1, 0, 9,  32'hA1, 32'h1000, f(32'hA1, 32'h1009), 2, 0, 0);
      vecs[19] = v(1, 0, 10, 32'hA2, 32'h1000, f(32'hA2, 32'h100A), 3, 0, 0);
      vecs[20] = v(1, 0, 11, 32'hA3, 32'h1000, f(32'hA3, 32'h100B), 3, 0, 0);
      vecs[21] = v(1, 0, 12, 32'hA4, 32'h1000, f(32'hA4, 32'h100C), 4, 1, 0);
      vecs[22] = v(1, 0, 13, 32'hA5, 32'h1000, f(32'hA5, 32'h100D), 4, 1, 0);
      vecs[23] = v(1, 0, 14, 32'hA6, 32'h1000, 32'h100E, 4, 1, 1);
      vecs[24] = v(0, 0, 0, 0, 32'h1000, 32'h1000, 3, 0, 1);
      vecs[25] = v(0, 0, 0, 0, 32'h1000, 32'h1000, 3, 0, 1);
      vecs[26] = v(0, 0, 0, 0, 32'h1000, 32'h1000, 2, 0, 1);
      vecs[27] = v(0, 0, 0, 0, 32'h1000, 32'h1000, 2, 0, 1);
      vecs[28] = v(0, 0, 0, 0, 32'h1000, 32'h1000, 1, 0, 1);
      vecs[29] = v(0, 0, 0, 0, 32'h1000, 32'h1000, 1, 0, 1);
      vecs[30] = v(0, 0, 0, 0, 32'h1000, 32'h1000, 0, 0, 1);
      vecs[31] = v(0, 0, 0, 0, 32'h1000, 32'h1000, 0, 0, 1);

      // Preload array[a] = 0x1000 + a through spaced-out stores that drain fully.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int a = 0; a < 16; a++) begin
         drive(1, 0, a, 32'h1000 + a);
         tick();
         drive(0, 0, 0, 0);
         repeat (3) tick();
      end

      rst = 1'b1;
      drive(0, 3, 3, 0);
      tick();
      check("reset inst", inst, 32'h0);
      check("reset mem_in", mem_in, 32'h0);
      check("reset sb_count", {29'd0, sb_count}, 32'd0);
      check("reset sb_full", {31'd0, sb_full}, 32'd0);
      check("reset overflow", {31'd0, overflow}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 32; i++) begin
         drive(vecs[i].we, vecs[i].pc, vecs[i].addr, vecs[i].data);
         tick();
         check($sformatf("row%0d inst", i), inst, vecs[i].e_inst);
         check($sformatf("row%0d mem_in", i), mem_in, vecs[i].e_mem);
         check($sformatf("row%0d sb_count", i), {29'd0, sb_count}, vecs[i].e_cnt);
         check($sformatf("row%0d sb_full", i), {31'd0, sb_full}, {31'd0, vecs[i].e_full});
         check($sformatf("row%0d overflow", i), {31'd0, overflow}, {31'd0, vecs[i].e_ovf});
      end

      // Accepted stores landed in push order; the dropped one at 14 never did.
      for (int a = 8; a <= 14; a++) begin
         logic [31:0] exp;
         exp = (a < 14) ? 32'hA0 + 32'(a - 8) : 32'h100E;
         drive(0, a, a, 0);
         tick();
         check($sformatf("readback%0d inst", a), inst, exp);
         check($sformatf("readback%0d mem_in", a), mem_in, exp);
      end
      check("overflow sticky", {31'd0, overflow}, 32'd1);

      // Reset one cycle into BUSY discards the buffer before anything drains.
      drive(1, 0, 1, 32'hB1); tick();
      drive(1, 0, 2, 32'hB2); tick();
      drive(1, 0, 3, 32'hB3); tick();
      check("pre-abort sb_count", {29'd0, sb_count}, 32'd3);
      rst = 1'b1;
      drive(0, 1, 1, 0);
      tick();
      check("abort inst", inst, 32'h0);
      check("abort mem_in", mem_in, 32'h0);
      check("abort sb_count", {29'd0, sb_count}, 32'd0);
      check("abort overflow", {31'd0, overflow}, 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("abort idle%0d sb_count", k), {29'd0, sb_count}, 32'd0);
      end
      for (int a = 1; a <= 3; a++) begin
         drive(0, a, a, 0);
         tick();
         check($sformatf("abort keep%0d inst", a), inst, 32'h1000 + a);
         check($sformatf("abort keep%0d mem_in", a), mem_in, 32'h1000 + a);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
